text_buffer_writer: RTL
=======================

Name: text_buffer_writer

Overview:
- Character-cell frame buffer that produces `ascii_code` for the VGA text renderer.
- Write side: accepts a byte stream (keyboard/UART) over a valid/ready handshake, keeps a cursor, and handles newline, backspace, wrap, scroll and clear.
- Read side: given the pixel `x`,`y`, returns the code of the cell under that pixel one clock later, bit 7 preserved as the Thai/ASCII language select.
- Sits between the input receiver and the text renderer; default geometry matches the 256x64-pixel text window at (192,208).

Parameters:
- COLS, 32, cells per row (power of two).
- ROWS, 4, rows (power of two).
- X0, 192, left pixel of text window.
- Y0, 208, top pixel of text window.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  `wr_char` is valid.
- wr_ready  out  1  block can accept a character this cycle.
- wr_char  in  8  character code; 0x80-0xFF selects the Thai glyph set.
- clear  in  1  one-cycle pulse: blank the buffer and home the cursor.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- ascii_code  out  8  code of the cell at (x,y), registered.
- cursor_col  out  log2(COLS)  cursor column.
- cursor_row  out  log2(ROWS)  cursor row.
- busy  out  1  CLEAR or SCROLL in progress.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low (`reset_n`).
- Storage: COLS*ROWS bytes.
  - cell index = {row, col}.
  - One synchronous write port.
  - Two asynchronous read ports: display and scroll-copy.
- Reset (reset_n=0 at a clk edge):
  - cursor=(0,0), ascii_code=0x20, state=CLEAR, sweep counter=0.
  - Outputs while held: wr_ready=0, busy=1.
  - Reset asserted mid-SCROLL or mid-CLEAR aborts the operation and restarts CLEAR.
- States and transitions:
  - IDLE:
    - wr_ready = ~clear; busy=0.
    - clear=1 -> CLEAR, cursor=(0,0). clear takes priority; a simultaneous wr_valid is not accepted.
    - Accepted character (wr_valid & wr_ready) is handled per the character rules below.
  - CLEAR:
    - Counter k=0..COLS*ROWS-1; mem[k]<=0x20, one cell per cycle.
    - After the last cell -> IDLE.
    - Duration COLS*ROWS cycles (128 at defaults); wr_ready=0, busy=1.
    - clear re-asserted during CLEAR is ignored.
  - SCROLL:
    - Counter k=0..COLS*ROWS-1.
    - k<COLS*(ROWS-1): mem[k]<=mem[k+COLS]; otherwise mem[k]<=0x20.
    - After the last cell -> IDLE with cursor=(ROWS-1,0).
    - 128 cycles; wr_ready=0, busy=1; clear is ignored.
- Character rules (applied on the acceptance cycle):
  - 0x0A or 0x0D: col=0.
    - row<ROWS-1: row+1.
    - Otherwise enter SCROLL.
  - 0x08 backspace:
    - col>0: col-1 and write 0x20 at the new position.
    - col=0, row>0: move to (row-1, COLS-1) and write 0x20 there.
    - At (0,0): no effect.
  - Printable (0x20-0x7E or 0x80-0xFF): write at cursor, then col+1.
    - At col=COLS-1: col=0, row+1.
    - At the last row and last column: write, then enter SCROLL.
  - Any other code (0x00-0x07, 0x09, 0x0B, 0x0C, 0x0E-0x1F, 0x7F): accepted and discarded; memory and cursor unchanged.
- Display read:
  - In window (X0<=x<X0+8*COLS and Y0<=y<Y0+16*ROWS): col=(x-X0)>>3, row=(y-Y0)>>4.
  - Next-cycle ascii_code = mem[{row,col}].
  - Outside the window: 0x20.
  - Latency exactly 1 clk.
  - Reads are never stalled; during CLEAR/SCROLL they return current memory contents, so a transient mix is acceptable.
  - Same-cycle write and read of one cell returns the old value.
- Arithmetic:
  - Subtractions are 10-bit unsigned, evaluated only when in the window.
  - Cursor fields wrap by explicit rules only; no modular overflow is relied on.

Test Plan:
- Release reset, hold wr_valid=1: busy=1 and wr_ready=0 for 128 cycles, then wr_ready=1. With x=192,y=208, ascii_code=0x20 one cycle later.
- Send 0x41, 0x42: cursor=(0,2). x=200,y=208 -> ascii_code=0x42 next cycle. x=191 -> 0x20.
- Cursor at (1,0), send 0x08: cursor=(0,31), cell(0,31)=0x20. Then send 0x08 from (0,0): no change.
- Fill 128 printable chars, row r holding 0x41+r:
  - After the 128th, busy=1 for 128 cycles and wr_ready=0.
  - Result: row0=0x42, row2=0x44, row3 all 0x20, cursor=(3,0).
  - Next char 0x45 lands at (3,0); cursor=(3,1).
- Same cycle clear=1 and wr_valid=1 with 0x5A: char not accepted (wr_ready=0), all cells 0x20 after 128 cycles, cursor=(0,0).
- Send 0xA1: cell=0xA1, and ascii_code at that cell is 0xA1 with bit7=1. Send 0x07: accepted, cursor and memory unchanged.

Source files
------------

// File: rtl/text_buffer_writer.sv
// Character-cell text buffer: byte-stream writer with cursor, wrap, scroll and clear,
// plus a one-cycle registered display read port for the VGA text renderer.
//
// state  | meaning
// IDLE   | accepting characters, cursor live
// CLEAR  | sweeping every cell to 0x20, cursor homed
// SCROLL | moving rows up by one, blanking the last row
module text_buffer_writer #(
  parameter int COLS = 32,
  parameter int ROWS = 4,
  parameter int X0   = 192,
  parameter int Y0   = 208,
  localparam int CW  = $clog2(COLS),
  localparam int RW  = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_char,
  input  logic          clear,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [7:0]    ascii_code,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          busy
);

  localparam int AW = CW + RW;
  localparam logic [AW-1:0] K_LAST     = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] SCROLL_LIM = AW'(COLS * (ROWS - 1));
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [9:0]    X_BEG      = 10'(X0);
  localparam logic [9:0]    X_END      = 10'(X0 + 8 * COLS);
  localparam logic [9:0]    Y_BEG      = 10'(Y0);
  localparam logic [9:0]    Y_END      = 10'(Y0 + 16 * ROWS);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

  state_t        state_q;
  logic [AW-1:0] k_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          busy_q;
  logic [7:0]    ascii_q;
  logic [7:0]    mem_q [COLS*ROWS];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [AW-1:0] scroll_src;
  logic          accept, is_nl, is_bs, is_prn, at_home;
  logic          in_win;
  logic [9:0]    dx, dy;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [7:0]    disp_code;

  assign wr_ready   = ~busy_q & ~clear;
  assign busy       = busy_q;
  assign ascii_code = ascii_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  assign accept  = wr_valid & wr_ready;
  assign is_nl   = (wr_char == 8'h0A) || (wr_char == 8'h0D);
  assign is_bs   = (wr_char == 8'h08);
  assign is_prn  = ((wr_char >= 8'h20) && (wr_char <= 8'h7E)) || wr_char[7];
  assign at_home = (row_q == '0) && (col_q == '0);

  // Source wraps past the end for the last row, but it is only used below SCROLL_LIM.
  assign scroll_src = k_q + AW'(COLS);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = k_q;
    mem_wdata = 8'h20;
    unique case (state_q)
      S_CLEAR: mem_we = 1'b1;
      S_SCROLL: begin
        mem_we = 1'b1;
        if (k_q < SCROLL_LIM) mem_wdata = mem_q[scroll_src];
      end
      S_IDLE: begin
        if (accept) begin
          if (is_bs && !at_home) begin
            mem_we    = 1'b1;
            mem_waddr = (col_q != '0) ? {row_q, col_q - CW'(1)} : {row_q - RW'(1), COL_LAST};
          end else if (is_prn) begin
            mem_we    = 1'b1;
            mem_waddr = {row_q, col_q};
            mem_wdata = wr_char;
          end
        end
      end
      default: ;
    endcase
    if (!reset_n) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    in_win = (x >= X_BEG) && (x < X_END) && (y >= Y_BEG) && (y < Y_END);
    dx = '0;
    dy = '0;
    if (in_win) begin
      dx = x - X_BEG;
      dy = y - Y_BEG;
    end
    rd_col    = CW'(dx >> 3);
    rd_row    = RW'(dy >> 4);
    disp_code = in_win ? mem_q[{rd_row, rd_col}] : 8'h20;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b1;
      ascii_q <= 8'h20;
    end else begin
      ascii_q <= disp_code;
      unique case (state_q)
        S_IDLE: begin
          if (clear) begin
            state_q <= S_CLEAR;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
          end else if (accept) begin
            if (is_nl) begin
              col_q <= '0;
              if (row_q != ROW_LAST) begin
                row_q <= row_q + RW'(1);
              end else begin
                state_q <= S_SCROLL;
                k_q     <= '0;
                busy_q  <= 1'b1;
              end
            end else if (is_bs) begin
              if (col_q != '0) begin
                col_q <= col_q - CW'(1);
              end else if (row_q != '0) begin
                row_q <= row_q - RW'(1);
                col_q <= COL_LAST;
              end
            end else if (is_prn) begin
              if (col_q == COL_LAST) begin
                col_q <= '0;
                if (row_q == ROW_LAST) begin
                  state_q <= S_SCROLL;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                end else begin
                  row_q <= row_q + RW'(1);
                end
              end else begin
                col_q <= col_q + CW'(1);
              end
            end
          end
        end
        S_CLEAR: begin
          if (k_q == K_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        S_SCROLL: begin
          if (k_q == K_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            row_q   <= ROW_LAST;
            col_q   <= '0;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
